// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               Contents: FSM state encoding, forward-select codes and the
//               load result-source code.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Memory-side controller state
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FAULT    = 2'b10
  } state_e;

  // Operand forward selects driven to the E-stage operand muxes
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

  // ResultSrc encoding that identifies a load in E
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Operand forward select for one E-stage source register.
//               The youngest writer (M) wins over W; x0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [ADDR_W-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        fwd_o
);

  // Pick the most recent producer of rs_i still in flight
  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Five-stage pipeline hazard controller: operand forwarding,
//               load-use stall, branch flush, data-memory wait handling with
//               timeout fault, optional stall-cycle performance counter.
//               Optional feature macro: PIPE_CTRL_PERF_CNT_EN
//               (defined: StallCycles_o counts StallF_o cycles;
//                undefined: StallCycles_o is tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int MEM_TIMEOUT            = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              EnE_o,
  output logic                              EnM_o,
  output logic                              EnW_o,
  output logic                              FlushW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              MemFault_o,
  output logic [31:0]                       StallCycles_o
);

  // The wait counter holds the number of MEM_WAIT cycles already spent;
  // the MEM_TIMEOUT-th wait cycle is the one where it equals MEM_TIMEOUT-1.
  localparam int               CNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_pending;
  logic             load_use;

  fwd_unit #(.ADDR_W(REGISTER_ADDRESS_WIDTH)) u_fwd_a (
    .rs_i          (Rs1E_i),
    .rd_m_i        (RdM_i),
    .reg_write_m_i (RegWriteM_i),
    .rd_w_i        (RdW_i),
    .reg_write_w_i (RegWriteW_i),
    .fwd_o         (ForwardAE_o)
  );

  fwd_unit #(.ADDR_W(REGISTER_ADDRESS_WIDTH)) u_fwd_b (
    .rs_i          (Rs2E_i),
    .rd_m_i        (RdM_i),
    .reg_write_m_i (RegWriteM_i),
    .rd_w_i        (RdW_i),
    .reg_write_w_i (RegWriteW_i),
    .fwd_o         (ForwardBE_o)
  );

  // Hazard detection terms shared by the FSM and the output decode
  always_comb begin
    mem_pending = MemReqM_i && !MemReadyM_i;
    load_use    = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                  ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  end

  // Next-state / wait-counter logic for the memory-side FSM
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_pending) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_pending) begin
          // Ready on the final allowed cycle still counts as completion
          state_d = ST_RUN;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline control decode; priority FAULT > memory stall > branch > load-use.
  // A branch in a frozen E stage is simply re-evaluated once the stall drops.
  always_comb begin
    StallF_o   = 1'b0;
    StallD_o   = 1'b0;
    FlushD_o   = 1'b0;
    FlushE_o   = 1'b0;
    EnE_o      = 1'b1;
    EnM_o      = 1'b1;
    EnW_o      = 1'b1;
    FlushW_o   = 1'b0;
    MemFault_o = 1'b0;
    if (state_q == ST_FAULT) begin
      MemFault_o = 1'b1;
      StallF_o   = 1'b1;
      StallD_o   = 1'b1;
      EnE_o      = 1'b0;
      EnM_o      = 1'b0;
      EnW_o      = 1'b0;
      FlushW_o   = 1'b1;
    end else if (mem_pending) begin
      // W keeps advancing but receives a bubble while M is held
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      EnE_o    = 1'b0;
      EnM_o    = 1'b0;
      FlushW_o = 1'b1;
    end else if (PCSrcE_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (load_use) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Count every fetch-stall cycle, wrapping naturally at 2^32
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (StallF_o) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Performance counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign StallCycles_o = stall_cycles_q;
`else
  assign StallCycles_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl: directed literal checks
//               plus randomized stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int AW      = 5;
  localparam int TIMEOUT = 8;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic          regwm, regww, pcsrc, memreq, memrdy;
  logic [1:0]    ressrc;
  logic          stallf, stalld, flushd, flushe, ene, enm, enw, flushw, memfault;
  logic [1:0]    fwda, fwdb;
  logic [31:0]   stallcyc;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(
    .REGISTER_ADDRESS_WIDTH(AW),
    .MEM_TIMEOUT           (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .Rs1D_i       (rs1d),
    .Rs2D_i       (rs2d),
    .Rs1E_i       (rs1e),
    .Rs2E_i       (rs2e),
    .RdE_i        (rde),
    .RdM_i        (rdm),
    .RdW_i        (rdw),
    .RegWriteM_i  (regwm),
    .RegWriteW_i  (regww),
    .ResultSrcE_i (ressrc),
    .PCSrcE_i     (pcsrc),
    .MemReqM_i    (memreq),
    .MemReadyM_i  (memrdy),
    .StallF_o     (stallf),
    .StallD_o     (stalld),
    .FlushD_o     (flushd),
    .FlushE_o     (flushe),
    .EnE_o        (ene),
    .EnM_o        (enm),
    .EnW_o        (enw),
    .FlushW_o     (flushw),
    .ForwardAE_o  (fwda),
    .ForwardBE_o  (fwdb),
    .MemFault_o   (memfault),
    .StallCycles_o(stallcyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_wait: consecutive cycles the M-stage access has been outstanding
  // (the first stalled cycle counts as 1). The access may stay outstanding
  // for the first cycle plus MEM_TIMEOUT further cycles; beyond that it faults.
  bit          m_fault;
  int          m_wait;
  logic [31:0] m_stalls;

  typedef struct packed {
    logic       sf, sd, fd, fe, ene, enm, enw, fw, mf;
    logic [1:0] fa, fb;
  } exp_t;

  function automatic logic [1:0] fwd_of(input logic [AW-1:0] rs);
    if (regwm && rdm != 0 && rdm == rs) return 2'd2;
    if (regww && rdw != 0 && rdw == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t calc();
    exp_t e;
    e = '{sf:1'b0, sd:1'b0, fd:1'b0, fe:1'b0, ene:1'b1, enm:1'b1, enw:1'b1,
          fw:1'b0, mf:1'b0, fa:2'd0, fb:2'd0};
    e.fa = fwd_of(rs1e);
    e.fb = fwd_of(rs2e);
    if (m_fault) begin
      e.mf = 1; e.sf = 1; e.sd = 1; e.ene = 0; e.enm = 0; e.enw = 0; e.fw = 1;
    end else if (memreq && !memrdy) begin
      e.sf = 1; e.sd = 1; e.ene = 0; e.enm = 0; e.fw = 1;
    end else if (pcsrc) begin
      e.fd = 1; e.fe = 1;
    end else if (ressrc == 2'b01 && rde != 0 && (rde == rs1d || rde == rs2d)) begin
      e.sf = 1; e.sd = 1; e.fe = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] perf_exp(input logic [31:0] n);
`ifdef PIPE_CTRL_PERF_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  // Advance the model state on each clock, clear it on reset
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_fault  = 0;
      m_wait   = 0;
      m_stalls = 0;
    end else begin
      e = calc();
      if (e.sf) m_stalls = m_stalls + 32'd1;
      if (!m_fault && memreq && !memrdy) begin
        m_wait++;
        if (m_wait > TIMEOUT) m_fault = 1;
      end else begin
        m_wait = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output with the model mid-cycle
  always @(negedge clk) begin
    exp_t e;
    e = calc();
    chk("StallF", {31'd0, stallf}, {31'd0, e.sf});
    chk("StallD", {31'd0, stalld}, {31'd0, e.sd});
    chk("FlushD", {31'd0, flushd}, {31'd0, e.fd});
    chk("FlushE", {31'd0, flushe}, {31'd0, e.fe});
    chk("EnE", {31'd0, ene}, {31'd0, e.ene});
    chk("EnM", {31'd0, enm}, {31'd0, e.enm});
    chk("EnW", {31'd0, enw}, {31'd0, e.enw});
    chk("FlushW", {31'd0, flushw}, {31'd0, e.fw});
    chk("MemFault", {31'd0, memfault}, {31'd0, e.mf});
    chk("ForwardAE", {30'd0, fwda}, {30'd0, e.fa});
    chk("ForwardBE", {30'd0, fwdb}, {30'd0, e.fb});
    chk("StallCycles", stallcyc, perf_exp(m_stalls));
  end

  // ---------------- stimulus helpers ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    regwm = 0; regww = 0; ressrc = 0; pcsrc = 0; memreq = 0; memrdy = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    next();
  endtask

  initial begin
    clear_inputs();
    m_fault = 0; m_wait = 0; m_stalls = 0;
    rst_n = 0;
    #3;
    chk("rst_memfault", {31'd0, memfault}, 32'd0);
    chk("rst_stallcyc", stallcyc, 32'd0);
    chk("rst_enm", {31'd0, enm}, 32'd1);
    chk("rst_stallf", {31'd0, stallf}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    next();

    // Forwarding: M beats W, x0 never forwarded
    rdm = 5; regwm = 1; rdw = 5; regww = 1; rs1e = 5;
    mid(); chk("fwdA_from_M", {30'd0, fwda}, 32'd2); chk("fwdB_none", {30'd0, fwdb}, 32'd0);
    next(); rdm = 0;
    mid(); chk("fwdA_from_W", {30'd0, fwda}, 32'd1);
    next(); rdm = 5; rs1e = 0; rs2e = 5;
    mid(); chk("fwdB_from_M", {30'd0, fwdb}, 32'd2); chk("fwdA_x0", {30'd0, fwda}, 32'd0);

    // Load-use stall, then branch overriding it
    next(); clear_inputs(); ressrc = 2'b01; rde = 3; rs2d = 3;
    mid(); chk("lu_stallf", {31'd0, stallf}, 32'd1); chk("lu_stalld", {31'd0, stalld}, 32'd1);
    chk("lu_flushe", {31'd0, flushe}, 32'd1); chk("lu_flushd", {31'd0, flushd}, 32'd0);
    next(); clear_inputs();
    mid(); chk("lu_released", {31'd0, stallf}, 32'd0);
    next(); ressrc = 2'b01; rde = 3; rs2d = 3; pcsrc = 1;
    mid(); chk("br_flushd", {31'd0, flushd}, 32'd1); chk("br_flushe", {31'd0, flushe}, 32'd1);
    chk("br_stallf", {31'd0, stallf}, 32'd0);

    // Memory wait of 4 cycles with a branch deferred behind it
    next(); clear_inputs();
    do_reset();
    memreq = 1; memrdy = 0; pcsrc = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("mw_enm", {31'd0, enm}, 32'd0); chk("mw_flushw", {31'd0, flushw}, 32'd1);
      chk("mw_enw", {31'd0, enw}, 32'd1); chk("mw_flushd", {31'd0, flushd}, 32'd0);
      next();
    end
    memrdy = 1;
    mid(); chk("mw_done_stallf", {31'd0, stallf}, 32'd0); chk("mw_done_enm", {31'd0, enm}, 32'd1);
    chk("mw_deferred_br", {31'd0, flushd}, 32'd1); chk("mw_stallcyc", stallcyc, perf_exp(32'd4));
    next(); clear_inputs();

    // Timeout: one first stall cycle plus TIMEOUT wait cycles, then FAULT
    do_reset();
    memreq = 1; memrdy = 0;
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      mid(); chk("to_nofault_yet", {31'd0, memfault}, 32'd0);
      next();
    end
    mid(); chk("to_fault", {31'd0, memfault}, 32'd1); chk("to_enw", {31'd0, enw}, 32'd0);
    next(); memreq = 0;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("to_sticky", {31'd0, memfault}, 32'd1); chk("to_stallf", {31'd0, stallf}, 32'd1);
      next();
    end
    #2 rst_n = 0;
    #1 chk("to_async_clear", {31'd0, memfault}, 32'd0); chk("to_async_stallf", {31'd0, stallf}, 32'd0);
    @(negedge clk); rst_n = 1;
    next();

    // Ready on the last allowed wait cycle completes without fault
    memreq = 1; memrdy = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      mid(); next();
    end
    memrdy = 1;
    mid(); chk("edge_ready_stallf", {31'd0, stallf}, 32'd0); chk("edge_ready_nofault", {31'd0, memfault}, 32'd0);
    next(); clear_inputs();
    mid(); chk("edge_after_nofault", {31'd0, memfault}, 32'd0);
    next();

    // Reset in the middle of a wait discards it; wait restarts from RUN
    memreq = 1; memrdy = 0;
    for (int i = 0; i < 5; i++) begin
      mid(); next();
    end
    #2 rst_n = 0;
    #1 chk("mid_rst_fault", {31'd0, memfault}, 32'd0); chk("mid_rst_stallcyc", stallcyc, 32'd0);
    @(negedge clk); rst_n = 1;
    next();
    // The half cycle after release already counted as the first stalled cycle
    for (int i = 0; i < TIMEOUT; i++) begin
      mid(); chk("mid_rst_rewait", {31'd0, memfault}, 32'd0);
      next();
    end
    mid(); chk("mid_rst_refault", {31'd0, memfault}, 32'd1);
    next(); clear_inputs();
    do_reset();

    // Randomized traffic
    begin
      int mode;
      mode = 1;
      for (int c = 0; c < 3000; c++) begin
        if (c % 64 == 0) mode = int'($urandom_range(0, 3));
        rs1d   = AW'($urandom_range(0, 3));
        rs2d   = AW'($urandom_range(0, 3));
        rs1e   = AW'($urandom_range(0, 3));
        rs2e   = AW'($urandom_range(0, 3));
        rde    = AW'($urandom_range(0, 3));
        rdm    = AW'($urandom_range(0, 3));
        rdw    = AW'($urandom_range(0, 3));
        regwm  = 1'($urandom_range(0, 1));
        regww  = 1'($urandom_range(0, 1));
        ressrc = 2'($urandom_range(0, 3));
        pcsrc  = ($urandom_range(0, 3) == 0);
        if (mode == 0) begin
          memreq = 1;
          memrdy = ($urandom_range(0, 15) == 0);
        end else begin
          memreq = 1'($urandom_range(0, 1));
          memrdy = 1'($urandom_range(0, 1));
        end
        if ((m_fault && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
          #2 rst_n = 0;
          @(negedge clk);
          rst_n = 1;
        end
        next();
      end
    end

    clear_inputs();
    mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REGISTER_ADDRESS_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum data-memory wait cycles before fault.
REQ-003 SHALL have ports clk_i input 1 (single clock) and rst_ni input 1 (reset, asynchronous, active-low).
REQ-004 SHALL have inputs Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i, each REGISTER_ADDRESS_WIDTH wide: stage register indices.
REQ-005 SHALL have inputs RegWriteM_i 1, RegWriteW_i 1, ResultSrcE_i 2 (2'b01 = load), PCSrcE_i 1 (taken branch/jump in E).
REQ-006 SHALL have inputs MemReqM_i 1 (M-stage load/store active) and MemReadyM_i 1 (memory completes this cycle).
REQ-007 SHALL have outputs StallF_o 1, StallD_o 1, FlushD_o 1, FlushE_o 1, EnE_o 1, EnM_o 1, EnW_o 1, FlushW_o 1.
REQ-008 SHALL have outputs ForwardAE_o 2, ForwardBE_o 2 (00 regfile, 01 W result, 10 M ALU result).
REQ-009 SHALL have outputs MemFault_o 1 (sticky timeout) and StallCycles_o 32 (performance count).

Function
REQ-010 SHALL drive ForwardAE_o=10 when RegWriteM_i, RdM_i!=0, RdM_i==Rs1E_i; else 01 when RegWriteW_i, RdW_i!=0, RdW_i==Rs1E_i; else 00; ForwardBE_o identically on Rs2E_i.
REQ-011 SHALL detect load-use when ResultSrcE_i==2'b01, RdE_i!=0, RdE_i equals Rs1D_i or Rs2D_i: StallF_o=StallD_o=1, FlushE_o=1, same cycle (combinational).
REQ-012 SHALL, on PCSrcE_i=1 with no memory stall, assert FlushD_o=FlushE_o=1 same cycle; branch flush overrides load-use stall (StallF_o=StallD_o=0).
REQ-013 SHALL implement FSM states RUN, MEM_WAIT, FAULT.
REQ-014 SHALL treat memory stall as MemReqM_i & !MemReadyM_i in RUN or MEM_WAIT: StallF_o=StallD_o=1, EnE_o=EnM_o=0, EnW_o=1, FlushW_o=1, FlushD_o=FlushE_o=0, same cycle.
REQ-015 SHALL transition RUN->MEM_WAIT on memory stall; MEM_WAIT->RUN on MemReadyM_i=1 or MemReqM_i=0.
REQ-016 SHALL count MEM_WAIT cycles in a counter cleared on entry to MEM_WAIT; on count reaching MEM_TIMEOUT with MemReadyM_i=0, transition to FAULT.
REQ-017 SHALL in FAULT hold MemFault_o=1, StallF_o=StallD_o=1, EnE_o=EnM_o=EnW_o=0, FlushW_o=1; FAULT exits only by reset.
REQ-018 SHALL give priority FAULT > memory stall > branch flush > load-use; a deferred branch (PCSrcE_i held in frozen E) takes effect on release.
REQ-019 SHALL drive EnE_o=EnM_o=EnW_o=1, all stall/flush outputs 0 when no condition applies.
REQ-020 SHALL accept MemReadyM_i=1 on the cycle MEM_TIMEOUT is reached as completion (RUN, no fault).

Reset
REQ-021 SHALL on rst_ni=0 asynchronously enter RUN, clear wait counter, MemFault_o=0, StallCycles_o=0.
REQ-022 SHALL, if reset asserts mid MEM_WAIT, discard the pending wait; first cycle after release evaluates inputs in RUN.

Configuration
REQ-023 SHALL, with PIPE_CTRL_PERF_CNT_EN defined, increment StallCycles_o (wrapping at 2^32) every cycle StallF_o=1.
REQ-024 SHALL, without PIPE_CTRL_PERF_CNT_EN, tie StallCycles_o to 0 with no counter flops.

Structure
REQ-025 SHALL place FSM state enum, forward-select constants (FWD_RF, FWD_W, FWD_M) and RESULT_SRC_LOAD in shared package pipe_ctrl_pkg.
REQ-026 SHALL implement forwarding (REQ-010) in sub-module fwd_unit, instantiated twice (A and B).

Verification
REQ-027 SHALL test RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; RdM=0 same -> 01.
REQ-028 SHALL test ResultSrcE=01, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 one cycle; add PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
REQ-029 SHALL test MemReqM=1, MemReadyM=0 for 4 cycles then 1 -> EnM=0, FlushW=1 for 4 cycles, RUN on 5th; StallCycles=4 with macro.
REQ-030 SHALL test MEM_TIMEOUT=8, MemReadyM held 0 -> FAULT, MemFault=1 sticky until rst_ni=0; ready on cycle 8 -> no fault.
REQ-031 SHALL test rst_ni pulsed low mid MEM_WAIT -> outputs reset asynchronously, RUN after release.
